// File: rtl/sad_min_select_if.sv
// Search-datapath to best-match-selector bus: per-position SADs in, window winners out.
interface sad_min_select_if;
  logic        search_start;
  logic        sad_valid;
  logic        sad_last;
  logic [63:0] SAD16x16;
  logic [17:0] SAD32x32;
  logic [4:0]  search_column_count;
  logic [6:0]  search_row_count;
  logic        busy;
  logic        result_valid;
  logic [63:0] best_sad16;
  logic [23:0] best_mvx16;
  logic [27:0] best_mvy16;
  logic [17:0] best_sad32;
  logic [5:0]  best_mvx32;
  logic [6:0]  best_mvy32;
  logic        protocol_err;

  modport master (
    output search_start, sad_valid, sad_last, SAD16x16, SAD32x32,
           search_column_count, search_row_count,
    input  busy, result_valid, best_sad16, best_mvx16, best_mvy16,
           best_sad32, best_mvx32, best_mvy32, protocol_err
  );
  modport slave (
    input  search_start, sad_valid, sad_last, SAD16x16, SAD32x32,
           search_column_count, search_row_count,
    output busy, result_valid, best_sad16, best_mvx16, best_mvy16,
           best_sad32, best_mvx32, best_mvy32, protocol_err
  );
endinterface

// File: rtl/sad_min_select.sv
// Minimum-SAD selector over a search window: 4x 16x16 + 1x 32x32 trackers, signed MVs out.
// Optional MV-cost term enabled by `define SAD_MIN_MV_COST_EN.
module sad_track #(
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          upd,
  input  logic [19:0]   cost,
  input  logic [SW-1:0] sad,
  input  logic [5:0]    mvx,
  input  logic [6:0]    mvy,
  output logic [SW-1:0] best_sad,
  output logic [5:0]    best_mvx,
  output logic [6:0]    best_mvy
);
  logic [19:0] best_cost;

  // Strict less-than: ties keep the earlier candidate.
  always_ff @(posedge clk or posedge rst)
    if (rst || clr) begin
      best_cost <= '1;
      best_sad  <= '1;
      best_mvx  <= '0;
      best_mvy  <= '0;
    end else if (upd && cost < best_cost) begin
      best_cost <= cost;
      best_sad  <= sad;
      best_mvx  <= mvx;
      best_mvy  <= mvy;
    end
endmodule

module sad_min_select #(
  parameter int COL_OFFSET   = 16,
  parameter int ROW_OFFSET   = 64,
  parameter int LAMBDA_SHIFT = 2
) (
  input logic              clk,
  input logic              rst_n,
  sad_min_select_if.slave  bus
);
  localparam int STAGES = 1;
`ifdef SAD_MIN_MV_COST_EN
  localparam bit MV_COST = 1'b1;
`else
  localparam bit MV_COST = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SEARCH, FLUSH} state_t;
  state_t state;

  logic [STAGES:0]      vld_pipe, last_pipe;
  logic                 accept;
  logic [5:0]           mvx, s1_mvx;
  logic [6:0]           mvy, s1_mvy;
  logic signed [19:0]   sx, sy;
  logic [19:0]          ax, ay, pen;
  logic [4:0][19:0]     s1_cost;
  logic [3:0][15:0]     s1_sad16, trk_sad16;
  logic [17:0]          s1_sad32, trk_sad32;
  logic [3:0][5:0]      trk_mvx16;
  logic [3:0][6:0]      trk_mvy16;
  logic [5:0]           trk_mvx32;
  logic [6:0]           trk_mvy32;

  assign accept = bus.sad_valid && state == SEARCH && !bus.search_start;
  assign mvx    = {1'b0, bus.search_column_count} - 6'(COL_OFFSET);
  assign mvy    = bus.search_row_count - 7'(ROW_OFFSET);
  assign sx     = 20'($signed(mvx));
  assign sy     = 20'($signed(mvy));
  assign ax     = sx[19] ? 20'(-sx) : 20'(sx);
  assign ay     = sy[19] ? 20'(-sy) : 20'(sy);
  assign pen    = MV_COST ? (ax + ay) << LAMBDA_SHIFT : '0;

  // Stage 1: register candidate, MVs and per-partition cost.
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
      s1_mvx    <= '0;
      s1_mvy    <= '0;
      s1_cost   <= '0;
      s1_sad16  <= '0;
      s1_sad32  <= '0;
    end else if (bus.search_start) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], accept};
      last_pipe <= {last_pipe[STAGES-1:0], accept & bus.sad_last};
      if (accept) begin
        s1_mvx   <= mvx;
        s1_mvy   <= mvy;
        s1_sad16 <= bus.SAD16x16;
        s1_sad32 <= bus.SAD32x32;
        for (int k = 0; k < 4; k++)
          s1_cost[k] <= 20'(bus.SAD16x16[16*k +: 16]) + pen;
        s1_cost[4] <= 20'(bus.SAD32x32) + pen;
      end
    end

  // Stage 2: independent trackers.
  for (genvar k = 0; k < 4; k++) begin : g_blk
    sad_track #(.SW(16)) u_trk (
      .clk(clk), .rst(rst_n), .clr(bus.search_start), .upd(vld_pipe[0]),
      .cost(s1_cost[k]), .sad(s1_sad16[k]), .mvx(s1_mvx), .mvy(s1_mvy),
      .best_sad(trk_sad16[k]), .best_mvx(trk_mvx16[k]), .best_mvy(trk_mvy16[k])
    );
  end

  sad_track #(.SW(18)) u_trk32 (
    .clk(clk), .rst(rst_n), .clr(bus.search_start), .upd(vld_pipe[0]),
    .cost(s1_cost[4]), .sad(s1_sad32), .mvx(s1_mvx), .mvy(s1_mvy),
    .best_sad(trk_sad32), .best_mvx(trk_mvx32), .best_mvy(trk_mvy32)
  );

  // Control FSM with registered outputs; results publish when the last sample has passed stage 2.
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      state            <= IDLE;
      bus.busy         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.protocol_err <= 1'b0;
      bus.best_sad16   <= '1;
      bus.best_mvx16   <= '0;
      bus.best_mvy16   <= '0;
      bus.best_sad32   <= '1;
      bus.best_mvx32   <= '0;
      bus.best_mvy32   <= '0;
    end else begin
      bus.result_valid <= 1'b0;
      if (bus.search_start) begin
        state            <= SEARCH;
        bus.busy         <= 1'b1;
        bus.protocol_err <= 1'b0;
      end else begin
        case (state)
          IDLE:
            if (bus.sad_valid) bus.protocol_err <= 1'b1;
          SEARCH:
            if (bus.sad_valid && bus.sad_last) state <= FLUSH;
          FLUSH: begin
            if (bus.sad_valid) bus.protocol_err <= 1'b1;
            if (last_pipe[STAGES]) begin
              state            <= IDLE;
              bus.busy         <= 1'b0;
              bus.result_valid <= 1'b1;
              bus.best_sad16   <= trk_sad16;
              bus.best_mvx16   <= trk_mvx16;
              bus.best_mvy16   <= trk_mvy16;
              bus.best_sad32   <= trk_sad32;
              bus.best_mvx32   <= trk_mvx32;
              bus.best_mvy32   <= trk_mvy32;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_sad_min_select.sv
// Directed self-checking bench for sad_min_select; expectations follow SAD_MIN_MV_COST_EN if defined.
module tb_sad_min_select;
  logic clk = 1'b0;
  logic rst_n;
  int   n_run = 0;
  int   n_fail = 0;

  sad_min_select_if bus();
  sad_min_select dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic drive(input logic [4:0] col, input logic [6:0] row,
                       input logic [17:0] s32, input logic [63:0] s16, input logic last);
    bus.sad_valid = 1'b1;
    bus.sad_last = last;
    bus.search_column_count = col;
    bus.search_row_count = row;
    bus.SAD32x32 = s32;
    bus.SAD16x16 = s16;
    @(negedge clk);
    bus.sad_valid = 1'b0;
    bus.sad_last = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.sad_valid = 1'b0;
    bus.sad_last = 1'b0;
    bus.search_start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic start();
    bus.search_start = 1'b1;
    bus.sad_valid = 1'b0;
    @(negedge clk);
    bus.search_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    idle(5);
    n_run++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    n_run++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %0b want 0", bus.result_valid); end
    n_run++; if (bus.protocol_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %0b want 0", bus.protocol_err); end
    n_run++; if (bus.best_sad32 !== 18'h3FFFF) begin n_fail++; $display("FAIL reset_sad32 got %h want 3ffff", bus.best_sad32); end
    n_run++; if (bus.best_sad16 !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL reset_sad16 got %h want all ones", bus.best_sad16); end
    n_run++; if ({bus.best_mvx16, bus.best_mvy16, bus.best_mvx32, bus.best_mvy32} !== 65'd0) begin
      n_fail++; $display("FAIL reset_mv got %h/%h/%h/%h want 0", bus.best_mvx16, bus.best_mvy16, bus.best_mvx32, bus.best_mvy32); end
  endtask

  task automatic test_basic();
    start();
    drive(5'd16, 7'd64, 18'd500, {4{16'd1000}}, 1'b0);
    drive(5'd20, 7'd60, 18'd300, {4{16'd1000}}, 1'b0);
    drive(5'd5,  7'd10, 18'd300, {4{16'd1000}}, 1'b1);
    n_run++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %0b want 1", bus.busy); end
    idle(1);
    n_run++; if (bus.result_valid !== 1'b0) begin n_fail++; $display("FAIL basic_rv_early got %0b want 0", bus.result_valid); end
    idle(1);
    n_run++; if (bus.result_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rv got %0b want 1", bus.result_valid); end
    n_run++; if (bus.best_sad32 !== 18'd300) begin n_fail++; $display("FAIL basic_sad32 got %0d want 300", bus.best_sad32); end
    n_run++; if (bus.best_mvx32 !== 6'h04 || bus.best_mvy32 !== 7'h7C) begin
      n_fail++; $display("FAIL basic_mv32 got %h,%h want 04,7c", bus.best_mvx32, bus.best_mvy32); end
    n_run++; if (bus.best_sad16 !== {4{16'd1000}} || bus.best_mvx16 !== 24'd0 || bus.best_mvy16 !== 28'd0) begin
      n_fail++; $display("FAIL basic_blk16 got %h %h %h want 1000s,0,0", bus.best_sad16, bus.best_mvx16, bus.best_mvy16); end
    idle(1);
    n_run++; if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse got rv=%0b busy=%0b want 0,0", bus.result_valid, bus.busy); end
  endtask

  task automatic test_sweep();
    logic [63:0] exp16;
    logic [23:0] exp_mvx16;
    logic [27:0] exp_mvy16;
    logic [5:0]  exp_mvx32;
    logic [6:0]  exp_mvy32;
    start();
    for (int r = 0; r < 128; r++)
      for (int c = 0; c < 32; c++)
        drive(5'(c), 7'(r), 18'd1000,
              {16'd1000, (r == 0 && c == 0) ? 16'd10 : 16'd1000, 16'd1000, 16'd1000},
              (r == 127 && c == 31));
    idle(2);
    exp16 = {16'd1000, 16'd10, 16'd1000, 16'd1000};
`ifdef SAD_MIN_MV_COST_EN
    exp_mvx16 = {6'h00, 6'h30, 6'h00, 6'h00};
    exp_mvy16 = {7'h00, 7'h40, 7'h00, 7'h00};
    exp_mvx32 = 6'h00;
    exp_mvy32 = 7'h00;
`else
    exp_mvx16 = {4{6'h30}};
    exp_mvy16 = {4{7'h40}};
    exp_mvx32 = 6'h30;
    exp_mvy32 = 7'h40;
`endif
    n_run++; if (bus.result_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_rv got %0b want 1", bus.result_valid); end
    n_run++; if (bus.best_sad16 !== exp16) begin n_fail++; $display("FAIL sweep_sad16 got %h want %h", bus.best_sad16, exp16); end
    n_run++; if (bus.best_mvx16 !== exp_mvx16 || bus.best_mvy16 !== exp_mvy16) begin
      n_fail++; $display("FAIL sweep_mv16 got %h,%h want %h,%h", bus.best_mvx16, bus.best_mvy16, exp_mvx16, exp_mvy16); end
    n_run++; if (bus.best_sad32 !== 18'd1000 || bus.best_mvx32 !== exp_mvx32 || bus.best_mvy32 !== exp_mvy32) begin
      n_fail++; $display("FAIL sweep_32 got %0d %h %h want 1000 %h %h", bus.best_sad32, bus.best_mvx32, bus.best_mvy32, exp_mvx32, exp_mvy32); end
  endtask

  task automatic test_abort();
    start();
    drive(5'd16, 7'd64, 18'd200, {4{16'd200}}, 1'b0);
    drive(5'd17, 7'd64, 18'd1, {4{16'd1}}, 1'b0);
    start();
    n_run++; if (bus.best_sad32 !== 18'd1000 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL abort_hold got sad32=%0d busy=%0b want 1000,1", bus.best_sad32, bus.busy); end
    drive(5'd16, 7'd64, 18'd200, {4{16'd200}}, 1'b0);
    drive(5'd17, 7'd64, 18'd50, {4{16'd50}}, 1'b0);
    drive(5'd18, 7'd64, 18'd80, {4{16'd80}}, 1'b1);
    idle(2);
    n_run++; if (bus.result_valid !== 1'b1 || bus.best_sad32 !== 18'd50) begin
      n_fail++; $display("FAIL abort_sad32 got rv=%0b sad=%0d want 1,50", bus.result_valid, bus.best_sad32); end
    n_run++; if (bus.best_sad16 !== {4{16'd50}} || bus.best_mvx32 !== 6'h01 || bus.best_mvy32 !== 7'h00) begin
      n_fail++; $display("FAIL abort_res got %h %h %h want 50s 01 00", bus.best_sad16, bus.best_mvx32, bus.best_mvy32); end
  endtask

  task automatic test_protocol();
    int rv_seen;
    rv_seen = 0;
    idle(1);
    drive(5'd16, 7'd64, 18'd0, 64'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (bus.result_valid !== 1'b0) rv_seen++;
      idle(1);
    end
    n_run++; if (bus.protocol_err !== 1'b1) begin n_fail++; $display("FAIL perr_set got %0b want 1", bus.protocol_err); end
    n_run++; if (rv_seen != 0 || bus.best_sad32 !== 18'd50) begin
      n_fail++; $display("FAIL perr_ignored got rv_cycles=%0d sad32=%0d want 0,50", rv_seen, bus.best_sad32); end
    start();
    n_run++; if (bus.protocol_err !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL perr_clear got perr=%0b busy=%0b want 0,1", bus.protocol_err, bus.busy); end
  endtask

  task automatic test_mv_cost_back_to_back();
    logic [17:0] exp_sad;
    logic [5:0]  exp_mvx;
`ifdef SAD_MIN_MV_COST_EN
    exp_sad = 18'd100; exp_mvx = 6'h00;
`else
    exp_sad = 18'd95;  exp_mvx = 6'h0A;
`endif
    start();
    drive(5'd16, 7'd64, 18'd100, {4{16'd100}}, 1'b0);
    drive(5'd26, 7'd64, 18'd95, {4{16'd95}}, 1'b1);
    idle(2);
    n_run++; if (bus.result_valid !== 1'b1 || bus.best_sad32 !== exp_sad || bus.best_mvx32 !== exp_mvx) begin
      n_fail++; $display("FAIL mvcost got rv=%0b sad=%0d mvx=%h want 1,%0d,%h", bus.result_valid, bus.best_sad32, bus.best_mvx32, exp_sad, exp_mvx); end
    n_run++; if (bus.best_sad16 !== {4{exp_sad[15:0]}}) begin
      n_fail++; $display("FAIL mvcost16 got %h want %h", bus.best_sad16, {4{exp_sad[15:0]}}); end
    start();
    n_run++; if (bus.busy !== 1'b1 || bus.result_valid !== 1'b0 || bus.best_sad32 !== exp_sad) begin
      n_fail++; $display("FAIL b2b_hold got busy=%0b rv=%0b sad=%0d want 1,0,%0d", bus.busy, bus.result_valid, bus.best_sad32, exp_sad); end
    drive(5'd16, 7'd64, 18'd7, {4{16'd7}}, 1'b1);
    idle(2);
    n_run++; if (bus.result_valid !== 1'b1 || bus.best_sad32 !== 18'd7) begin
      n_fail++; $display("FAIL b2b_res got rv=%0b sad=%0d want 1,7", bus.result_valid, bus.best_sad32); end
  endtask

  task automatic test_reset_mid();
    int rv_seen;
    rv_seen = 0;
    start();
    drive(5'd16, 7'd64, 18'd3, {4{16'd3}}, 1'b0);
    drive(5'd17, 7'd64, 18'd2, {4{16'd2}}, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    n_run++; if (bus.busy !== 1'b0 || bus.best_sad32 !== 18'h3FFFF) begin
      n_fail++; $display("FAIL rstmid_clear got busy=%0b sad32=%h want 0,3ffff", bus.busy, bus.best_sad32); end
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.result_valid !== 1'b0) rv_seen++;
      idle(1);
    end
    n_run++; if (rv_seen != 0 || bus.best_sad16 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++; $display("FAIL rstmid_norv got rv_cycles=%0d sad16=%h want 0,all ones", rv_seen, bus.best_sad16); end
  endtask

  initial begin
    bus.search_start = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad_last = 1'b0;
    bus.SAD16x16 = '0;
    bus.SAD32x32 = '0;
    bus.search_column_count = '0;
    bus.search_row_count = '0;
    test_reset();
    test_basic();
    test_sweep();
    test_abort();
    test_protocol();
    test_mv_cost_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/sad_min_select.md
# sad_min_select

Best-match selector directly downstream of the basic-layer search datapath. Each valid search position supplies four 16x16 SADs and one 32x32 SAD together with the position's column/row counters. The block tracks the minimum-cost candidate per partition over a full search window and converts the winning counters into signed motion vectors. At the end of the window it emits a one-cycle result strobe and holds the results for the next refinement stage.

## Interface
Parameters:
- COL_OFFSET, 16: subtracted from search_column_count to form mv_x.
- ROW_OFFSET, 64: subtracted from search_row_count to form mv_y.
- LAMBDA_SHIFT, 2: left shift applied to MV cost; used only with SAD_MIN_MV_COST_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-high reset. The name is kept for codebase consistency; asserted = 1.
- search_start  in  1  one-cycle pulse; clears all trackers and enters SEARCH.
- sad_valid  in  1  SAD inputs and counters are valid this cycle.
- sad_last  in  1  qualifies sad_valid; marks the final position of the window.
- SAD16x16  in  64  four 16-bit SADs; block k (raster order, 0 = top-left) at [16k+15:16k].
- SAD32x32  in  18  32x32 SAD.
- search_column_count  in  5  candidate column, 0..31.
- search_row_count  in  7  candidate row, 0..127.
- busy  out  1  high in SEARCH and FLUSH.
- result_valid  out  1  one-cycle pulse when results update.
- best_sad16  out  64  winning SAD per 16x16 block, same packing as SAD16x16.
- best_mvx16  out  24  4 x 6-bit two's-complement mv_x, block k at [6k+5:6k].
- best_mvy16  out  28  4 x 7-bit two's-complement mv_y, block k at [7k+6:7k].
- best_sad32  out  18  winning 32x32 SAD.
- best_mvx32  out  6  mv_x of the 32x32 winner.
- best_mvy32  out  7  mv_y of the 32x32 winner.
- protocol_err  out  1  sticky; set by sad_valid while in IDLE, cleared by search_start.

## Operation
- The FSM has three states: IDLE, SEARCH and FLUSH.
  - IDLE -> SEARCH on search_start.
  - SEARCH -> FLUSH on sad_valid & sad_last.
  - FLUSH -> IDLE after the pipeline drains (1 cycle). result_valid pulses on this transition.
  - search_start in any state forces SEARCH, clears trackers and pipeline, and discards any same-cycle sad_valid.
- Stage 1 registers the inputs when sad_valid is high in SEARCH. It computes:
  - mv_x = col - COL_OFFSET (6-bit signed).
  - mv_y = row - ROW_OFFSET (7-bit signed).
  - cost = zero-extended SAD, 20 bits.
- Stage 2 runs per partition (5 independent trackers). If cost < best_cost (strict), it updates best_cost, best_sad and best_mv.
  - Ties keep the earlier candidate.
  - best_cost initialises to 20'hFFFFF, so the first valid sample always wins.
- sad_valid in IDLE or FLUSH is ignored and sets protocol_err.
- sad_last without sad_valid is ignored.
- Result outputs change only on the cycle result_valid pulses. They hold between searches, including across a new search_start until that search completes.

## Timing
- Reset values: busy=0, result_valid=0, protocol_err=0, best_sad16=64'hFFFF_FFFF_FFFF_FFFF, best_sad32=18'h3FFFF, all MVs=0. Internal trackers and FSM return to IDLE.
- Throughput: one candidate per cycle with no back-pressure. sad_valid may be high every cycle.
- Latency: sad_valid&sad_last sampled at edge N; result_valid is high during cycle N+2, with outputs updated at that same edge.
- Back-to-back: search_start may arrive during the result_valid cycle. The new search starts and the held results are unaffected.
- Reset asserted mid-search: all state clears immediately and no result_valid is produced.

## Configuration
- SAD_MIN_MV_COST_EN.
  - Defined: cost = SAD + ((|mv_x| + |mv_y|) << LAMBDA_SHIFT), computed in 20 bits. The comparison uses cost; best_sad still reports the raw SAD of the winner. The tie rule is unchanged.
  - Undefined: cost = SAD, and LAMBDA_SHIFT is unused.

## Test plan
- Reset, then idle 5 cycles -> busy=0, result_valid=0, best_sad32=3FFFF, MVs=0.
- Start, then 3 candidates (col,row,SAD32) = (16,64,500), (20,60,300), (5,10,300) with last on the third -> result_valid 2 cycles after last; best_sad32=300, mv=(+4,-4); tie keeps the earlier candidate.
- Start, then full 32x128 sweep with block 2 SAD=10 only at (0,0) and all others 1000 -> block 2 sad=10, mv=(-16,-64); other blocks sad=1000, mv=(-16,-64).
- search_start pulsed mid-sweep after a SAD=1 candidate, then new window with minimum 50 -> reported 50; the aborted candidate is absent.
- sad_valid in IDLE -> protocol_err=1 and results unchanged. A following search_start -> protocol_err=0.
- With SAD_MIN_MV_COST_EN and LAMBDA_SHIFT=2: candidates (16,64,100) and (26,64,95) -> costs 100 vs 135, winner SAD 100, mv=(0,0). Without the macro the winner is SAD 95, mv=(+10,0).
